trng_word_packer: RTL

Downstream consumer of the trng block's serial output (out_valid/out).
- Runs a continuous repetition-count health test on the accepted bit stream.
- Packs accepted bits LSB-first into WORD_W-bit words and buffers them in a DEPTH-entry FIFO.
- Presents words on a valid/ready interface to the host/bus side.
- Latches sticky overflow and health-failure flags for software.

---
 rtl/trng_word_packer_if.sv | 25 ++
 rtl/trng_word_packer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/trng_word_packer_if.sv
// Host-facing bundle of the TRNG word packer: serial bit input, word
// valid/ready output, and the fill/overflow/health status lines.
interface trng_word_packer_if #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
);
  logic                       in_valid;
  logic                       in_bit;
  logic                       word_valid;
  logic                       word_ready;
  logic [WORD_W-1:0]          word;
  logic [$clog2(DEPTH):0]     fill_level;
  logic                       overflow;
  logic                       health_fail;

  modport master (
    output in_valid, in_bit, word_ready,
    input  word_valid, word, fill_level, overflow, health_fail
  );

  modport slave (
    input  in_valid, in_bit, word_ready,
    output word_valid, word, fill_level, overflow, health_fail
  );
endinterface

// File: rtl/trng_word_packer.sv
// Packs accepted TRNG bits LSB-first into words, buffers them in a small FIFO,
// and runs a repetition-count health test that latches and flushes on failure.
module trng_word_packer #(
  parameter int WORD_W     = 8,
  parameter int DEPTH      = 4,
  parameter int RCT_CUTOFF = 32
) (
  input logic               clk,
  input logic               reset,
  trng_word_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(WORD_W);
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  logic [FW-1:0]     wr_ptr_r;
  logic [FW-1:0]     rd_ptr_r;
  logic [FW-1:0]     fill_r;
  logic              word_valid_r;
  logic              overflow_r;
  logic              health_fail_r;
  logic              prev_bit_r;
  logic [CW-1:0]     bit_cnt_r;
  logic [WORD_W-1:0] shift_r;
  logic [RW-1:0]     run_cnt_r;
  logic [WORD_W-1:0] mem_r [DEPTH];

  logic              accept_s;
  logic              pop_s;
  logic              full_s;
  logic              word_done_s;
  logic              fail_s;
  logic              push_s;
  logic              drop_s;
  logic [WORD_W-1:0] packed_s;
  logic [RW-1:0]     run_next_s;
  logic [FW-1:0]     fill_next_s;

  // Acceptance, packing, health-test and FIFO control decisions for this edge.
  always_comb begin
    accept_s    = bus.in_valid && !health_fail_r;
    pop_s       = word_valid_r && bus.word_ready;
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    packed_s    = shift_r;
    packed_s[bit_cnt_r] = bus.in_bit;
    word_done_s = accept_s && (bit_cnt_r == CW'(WORD_W - 1));

    // A zero run count means no bit has been seen since reset.
    if (!accept_s) begin
      run_next_s = run_cnt_r;
    end else if ((run_cnt_r != RW'(0)) && (bus.in_bit == prev_bit_r)) begin
      if (run_cnt_r == RW'(RCT_CUTOFF)) begin
        run_next_s = run_cnt_r;
      end else begin
        run_next_s = run_cnt_r + RW'(1);
      end
    end else begin
      run_next_s = RW'(1);
    end

    fail_s = accept_s && (run_next_s == RW'(RCT_CUTOFF));
    push_s = word_done_s && !fail_s && (!full_s || pop_s);
    drop_s = word_done_s && !fail_s && full_s && !pop_s;

    if (push_s && !pop_s) begin
      fill_next_s = fill_r + FW'(1);
    end else if (!push_s && pop_s) begin
      fill_next_s = fill_r - FW'(1);
    end else begin
      fill_next_s = fill_r;
    end
  end

  // Control state: pointers, fill, flags, packer and run counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r      <= FW'(0);
      rd_ptr_r      <= FW'(0);
      fill_r        <= FW'(0);
      word_valid_r  <= 1'b0;
      overflow_r    <= 1'b0;
      health_fail_r <= 1'b0;
      prev_bit_r    <= 1'b0;
      bit_cnt_r     <= CW'(0);
      shift_r       <= WORD_W'(0);
      run_cnt_r     <= RW'(0);
    end else begin
      if (fail_s) begin
        // Flush everything buffered and discard any word completing now.
        health_fail_r <= 1'b1;
        rd_ptr_r      <= wr_ptr_r;
        fill_r        <= FW'(0);
        word_valid_r  <= 1'b0;
        bit_cnt_r     <= CW'(0);
        shift_r       <= WORD_W'(0);
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + FW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + FW'(1);
        end
        fill_r       <= fill_next_s;
        word_valid_r <= (fill_next_s != FW'(0));
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
        if (accept_s) begin
          if (word_done_s) begin
            bit_cnt_r <= CW'(0);
            shift_r   <= WORD_W'(0);
          end else begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
            shift_r   <= packed_s;
          end
        end
      end
      if (accept_s) begin
        run_cnt_r  <= run_next_s;
        prev_bit_r <= bus.in_bit;
      end
    end
  end

  // FIFO storage; the completed word includes the bit accepted this edge.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= packed_s;
    end
  end

  assign bus.word        = mem_r[rd_ptr_r[AW-1:0]];
  assign bus.word_valid  = word_valid_r;
  assign bus.fill_level  = fill_r;
  assign bus.overflow    = overflow_r;
  assign bus.health_fail = health_fail_r;
endmodule
